// File: rtl/uart_tx_monitor.sv
// uart_tx_monitor: 8N1 UART receiver for the SoC TXD line with a show-ahead byte FIFO,
// good-frame counter and sticky framing/overrun flags.
module uart_tx_monitor #(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 4
) (
    input  logic        XCLK,
    input  logic        XRES,
    input  logic        RXD,
    input  logic        RD_EN,
    input  logic        CLR_ERR,
    output logic [7:0]  RD_DATA,
    output logic        EMPTY,
    output logic        FULL,
    output logic        FRAME_ERR,
    output logic        OVERRUN,
    output logic [15:0] BYTE_CNT
);
    localparam int CW    = $clog2(BAUD_DIV);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0] L_HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] L_BIT  = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t             r_state, w_next;
    logic               r_rx_meta, r_rxs;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic               r_push;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wp, r_rp;
    logic [FIFO_AW:0]   r_count, w_count_nx;
    logic               r_empty, r_full;
    logic               w_tick, w_good, w_bad, w_pop, w_push_ok;

    // Both flops reset high so reset release never looks like a start edge
    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= RXD;
            r_rxs     <= r_rx_meta;
        end
    end

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) r_state <= IDLE;
        else      r_state <= w_next;
    end

    assign w_tick = (r_cnt == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!r_rxs) w_next = START;
            START:   if (w_tick) w_next = r_rxs ? IDLE : DATA;
            DATA:    if (w_tick && r_idx == 3'd7) w_next = STOP;
            STOP:    if (w_tick) w_next = r_rxs ? IDLE : WAIT_HI;
            WAIT_HI: if (r_rxs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_good = (r_state == STOP) && w_tick && r_rxs;
        w_bad  = (r_state == STOP) && w_tick && !r_rxs;
    end

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_push    <= 1'b0;
            BYTE_CNT  <= '0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            r_cnt     <= (r_state == IDLE) ? L_HALF : w_tick ? L_BIT : r_cnt - 1'b1;
            r_push    <= w_good;
            BYTE_CNT  <= w_good ? BYTE_CNT + 16'd1 : BYTE_CNT;
            FRAME_ERR <= w_bad | (FRAME_ERR & ~CLR_ERR);
            OVERRUN   <= (r_push & ~w_push_ok) | (OVERRUN & ~CLR_ERR);
            if (r_state == START) begin
                r_idx <= '0;
            end else if (r_state == DATA && w_tick) begin
                r_shift[r_idx] <= r_rxs;
                r_idx          <= r_idx + 3'd1;
            end
        end
    end

    // A pop in the push cycle frees the slot, so a full FIFO can still accept
    assign w_pop      = RD_EN & ~r_empty;
    assign w_push_ok  = r_push & (~r_full | w_pop);
    assign w_count_nx = r_count + (FIFO_AW + 1)'(w_push_ok) - (FIFO_AW + 1)'(w_pop);

    always_ff @(posedge XCLK) begin
        if (w_push_ok) r_mem[r_wp] <= r_shift;
    end

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_wp    <= w_push_ok ? r_wp + 1'b1 : r_wp;
            r_rp    <= w_pop ? r_rp + 1'b1 : r_rp;
            r_count <= w_count_nx;
            r_empty <= (w_count_nx == '0);
            r_full  <= (w_count_nx == (FIFO_AW + 1)'(DEPTH));
        end
    end

    assign RD_DATA = r_empty ? 8'h00 : r_mem[r_rp];
    assign EMPTY   = r_empty;
    assign FULL    = r_full;
endmodule
